// File: rtl/btn_deb_multi_if.sv
// rtl/btn_deb_multi_if.sv - signal bundle between raw buttons and the debouncer
//
// Purpose: groups the raw button inputs and all debounced outputs so the
//          debouncer and its consumers share one connection point.
// Signals:
//   btn_in      [BT_WIDTH] raw button levels, asynchronous to clk
//   btn_out     [BT_WIDTH] debounced level, same polarity as btn_in
//   btn_press   [BT_WIDTH] one-cycle pulse when btn_out becomes the pressed level
//   btn_release [BT_WIDTH] one-cycle pulse when btn_out leaves the pressed level
//   sample_tick            one-cycle prescaler tick
//   btn_long    [BT_WIDTH] long-press pulse (only with BTN_DEB_LONG_PRESS_EN)
// Modports: master = debouncer side, slave = consumer side.
interface btn_deb_multi_if #(
  parameter int BT_WIDTH = 8
);
  logic [BT_WIDTH-1:0] btn_in;
  logic [BT_WIDTH-1:0] btn_out;
  logic [BT_WIDTH-1:0] btn_press;
  logic [BT_WIDTH-1:0] btn_release;
  logic                sample_tick;
`ifdef BTN_DEB_LONG_PRESS_EN
  logic [BT_WIDTH-1:0] btn_long;
`endif

  modport master (
    input  btn_in,
`ifdef BTN_DEB_LONG_PRESS_EN
    output btn_long,
`endif
    output btn_out, btn_press, btn_release, sample_tick
  );

  modport slave (
    output btn_in,
`ifdef BTN_DEB_LONG_PRESS_EN
    input  btn_long,
`endif
    input  btn_out, btn_press, btn_release, sample_tick
  );
endinterface

// File: rtl/btn_deb_multi.sv
// rtl/btn_deb_multi.sv - parametrised multi-channel button debouncer
//
// Purpose: synchronises each button, samples it on a shared prescaler tick
//          and changes the debounced level only after STABLE_N consecutive
//          ticks disagree with it. Emits press/release pulses per channel.
// Optional: macro BTN_DEB_LONG_PRESS_EN adds parameter LONG_N and output
//           btn_long (one pulse per press once held for LONG_N ticks).
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    btn_deb_multi_if.master (btn_in in; btn_out, btn_press,
//          btn_release, sample_tick[, btn_long] out)
module btn_deb_multi #(
  parameter int   BT_WIDTH = 8,
  parameter int   TICK_W   = 18,
  parameter int   STABLE_N = 4,
  parameter logic BTN_ACT  = 1'b1
`ifdef BTN_DEB_LONG_PRESS_EN
  , parameter logic [7:0] LONG_N = 8'd100
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  btn_deb_multi_if.master  bus
);

  localparam logic [3:0]          STAB_LAST = 4'(STABLE_N - 1);
  localparam logic [BT_WIDTH-1:0] IDLE_LVL  = {BT_WIDTH{~BTN_ACT}};

  logic [TICK_W-1:0]        presc_q, presc_d;
  logic                     tick;
  logic [BT_WIDTH-1:0]      sync1_q, sync2_q;
  logic [BT_WIDTH-1:0]      btn_out_q, btn_out_d;
  logic [BT_WIDTH-1:0]      press_q, press_d;
  logic [BT_WIDTH-1:0]      release_q, release_d;
  logic [BT_WIDTH-1:0][3:0] stab_q, stab_d;

  // Tick is decoded from the count rather than registered so the first one
  // lands exactly 2^TICK_W-1 edges after reset release.
  assign tick    = &presc_q;
  assign presc_d = presc_q + TICK_W'(1);

  always_comb begin
    btn_out_d = btn_out_q;
    stab_d    = stab_q;
    press_d   = '0;
    release_d = '0;
    if (tick) begin
      for (int i = 0; i < BT_WIDTH; i++) begin
        if (sync2_q[i] == btn_out_q[i]) begin
          // One agreeing sample discards any run in progress.
          stab_d[i] = '0;
        end else if (stab_q[i] == STAB_LAST) begin
          btn_out_d[i] = sync2_q[i];
          stab_d[i]    = '0;
          press_d[i]   = (sync2_q[i] == BTN_ACT);
          release_d[i] = (sync2_q[i] != BTN_ACT);
        end else begin
          stab_d[i] = stab_q[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      sync1_q   <= IDLE_LVL;
      sync2_q   <= IDLE_LVL;
      btn_out_q <= IDLE_LVL;
      press_q   <= '0;
      release_q <= '0;
      stab_q    <= '0;
    end else begin
      presc_q   <= presc_d;
      sync1_q   <= bus.btn_in;
      sync2_q   <= sync1_q;
      btn_out_q <= btn_out_d;
      press_q   <= press_d;
      release_q <= release_d;
      stab_q    <= stab_d;
    end
  end

  assign bus.btn_out     = btn_out_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
  assign bus.sample_tick = tick;

`ifdef BTN_DEB_LONG_PRESS_EN
  logic [BT_WIDTH-1:0][7:0] long_cnt_q, long_cnt_d;
  logic [BT_WIDTH-1:0]      long_q, long_d;

  // Counter saturates at LONG_N, so the pulse fires once per press.
  always_comb begin
    long_cnt_d = long_cnt_q;
    long_d     = '0;
    for (int i = 0; i < BT_WIDTH; i++) begin
      if (btn_out_q[i] != BTN_ACT) begin
        long_cnt_d[i] = '0;
      end else if (tick && (long_cnt_q[i] != LONG_N)) begin
        long_cnt_d[i] = long_cnt_q[i] + 8'd1;
        long_d[i]     = (long_cnt_d[i] == LONG_N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_cnt_q <= '0;
      long_q     <= '0;
    end else begin
      long_cnt_q <= long_cnt_d;
      long_q     <= long_d;
    end
  end

  assign bus.btn_long = long_q;
`endif

endmodule

// File: tb/tb_btn_deb_multi.sv
// tb/tb_btn_deb_multi.sv - self-checking bench for btn_deb_multi
module tb_btn_deb_multi;

  localparam int   BT_WIDTH = 4;
  localparam int   TICK_W   = 4;
  localparam int   STABLE_N = 3;
  localparam logic BTN_ACT  = 1'b1;
  localparam int   TP       = 16;
  localparam int   LONG_T   = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] out;
  } evt_t;

  evt_t       sb_q[$];
  int         long_q[$];
  logic [3:0] exp_out = 4'h0;
  int         pat[12] = '{1, 1, 0, 1, 1, 0, 1, 0, 1, 1, 0, 1};

  btn_deb_multi_if #(.BT_WIDTH(BT_WIDTH)) bus ();

  btn_deb_multi #(
    .BT_WIDTH(BT_WIDTH),
    .TICK_W  (TICK_W),
    .STABLE_N(STABLE_N),
    .BTN_ACT (BTN_ACT)
`ifdef BTN_DEB_LONG_PRESS_EN
    , .LONG_N(8'(LONG_T))
`endif
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Edge index since reset release: edge n lands cyc == n.
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic align(input int ph);
    int k = 0;
    while ((cyc % TP) != ph && k < TP) begin
      step(1);
      k++;
    end
  endtask

  // Input changed just after edge n0: synchronised value is seen by edges
  // >= n0+3; the level flips on the third tick edge from there.
  function automatic int third_tick(input int n0);
    return ((n0 + 3 + TP - 1) / TP) * TP + 2 * TP;
  endfunction

  task automatic push_evt(input int c, input logic [3:0] p, input logic [3:0] r, input logic [3:0] o);
    evt_t e;
    e.cyc = c; e.press = p; e.rel = r; e.out = o;
    sb_q.push_back(e);
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    while (sb_q.size() != 0 && k < budget) begin
      step(1);
      k++;
    end
    check(tag, sb_q.size(), 0);
  endtask

  // Scoreboard monitor: every pulse must match the next queued event.
  initial begin
    evt_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_out = 4'h0;
      end else begin
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
          e = sb_q.pop_front();
          check("evt_missed", cyc, e.cyc);
        end
        if (bus.btn_press != 0 || bus.btn_release != 0) begin
          if (sb_q.size() == 0) begin
            check("unexpected_pulse", {bus.btn_press, bus.btn_release}, 0);
          end else begin
            e = sb_q.pop_front();
            check("evt_cyc", cyc, e.cyc);
            check("evt_press", bus.btn_press, e.press);
            check("evt_release", bus.btn_release, e.rel);
            check("evt_out", bus.btn_out, e.out);
            exp_out = e.out;
          end
        end else if (bus.btn_out !== exp_out) begin
          check("out_track", bus.btn_out, exp_out);
          exp_out = bus.btn_out;
        end
`ifdef BTN_DEB_LONG_PRESS_EN
        while (long_q.size() > 0 && long_q[0] < cyc)
          check("long_missed", cyc, long_q.pop_front());
        if (bus.btn_long != 0) begin
          if (long_q.size() == 0) begin
            check("unexpected_long", bus.btn_long, 0);
          end else begin
            check("long_cyc", cyc, long_q.pop_front());
            check("long_ch", bus.btn_long, 4'h1);
          end
        end
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t1, t2, n0, tp;

    // 1. reset state and tick cadence
    bus.btn_in = 4'hF;
    rst_n = 1'b0;
    step(3);
    check("rst_out", bus.btn_out, 4'h0);
    check("rst_press", bus.btn_press, 4'h0);
    check("rst_release", bus.btn_release, 4'h0);
    check("rst_tick", bus.sample_tick, 1'b0);
    bus.btn_in = 4'h0;
    step(2);
    rst_n = 1'b1;
    t1 = -1; t2 = -1;
    for (int k = 0; k < 40; k++) begin
      step(1);
      if (bus.sample_tick) begin
        if (t1 < 0) t1 = cyc;
        else if (t2 < 0) t2 = cyc;
      end
    end
    check("tick_first", t1, 15);
    check("tick_second", t2, 31);

    // 2. clean press on channel 0
    align(4);
    n0 = cyc;
    bus.btn_in[0] = 1'b1;
    tp = third_tick(n0);
    push_evt(tp, 4'h1, 4'h0, 4'h1);
`ifdef BTN_DEB_LONG_PRESS_EN
    long_q.push_back(tp + LONG_T * TP);
`endif
    drain("t2_drain", 80);
    check("t2_out", bus.btn_out, 4'h1);

    // 3. bounce on channel 1: never three agreeing ticks in a row
    for (int k = 0; k < 12; k++) begin
      align(8);
      bus.btn_in[1] = pat[k][0];
      step(1);
    end
    align(8);
    bus.btn_in[1] = 1'b0;
    step(3 * TP);
    check("t3_out", bus.btn_out, 4'h1);

    // 4. short glitch on channel 2, then release channel 0
    align(3);
    bus.btn_in[2] = 1'b1;
    step(5);
    bus.btn_in[2] = 1'b0;
    step(20);
    check("t4_glitch_out", bus.btn_out, 4'h1);
    n0 = cyc;
    bus.btn_in[0] = 1'b0;
    push_evt(third_tick(n0), 4'h0, 4'h1, 4'h0);
    drain("t4_drain", 80);
    check("t4_out", bus.btn_out, 4'h0);

    // 5a. simultaneous press/release on channels 0 and 3
    n0 = cyc;
    bus.btn_in = 4'h9;
    push_evt(third_tick(n0), 4'h9, 4'h0, 4'h9);
    drain("t5_press_drain", 80);
    n0 = cyc;
    bus.btn_in = 4'h0;
    push_evt(third_tick(n0), 4'h0, 4'h9, 4'h0);
    drain("t5_rel_drain", 80);

    // 5b. reset after two agreeing ticks discards the partial count
    align(4);
    bus.btn_in = 4'h9;
    align(1);
    step(1);
    align(1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_out", bus.btn_out, 4'h0);
    check("t5_rst_tick", bus.sample_tick, 1'b0);
    step(3);
    rst_n = 1'b1;
    push_evt(third_tick(0), 4'h9, 4'h0, 4'h9);
    drain("t5_restart_drain", 80);
    n0 = cyc;
    bus.btn_in = 4'h0;
    push_evt(third_tick(n0), 4'h0, 4'h9, 4'h0);
    drain("t5_final_drain", 80);

`ifdef BTN_DEB_LONG_PRESS_EN
    // 6. long press: one pulse LONG_T ticks after press, none after
    n0 = cyc;
    bus.btn_in[0] = 1'b1;
    tp = third_tick(n0);
    push_evt(tp, 4'h1, 4'h0, 4'h1);
    long_q.push_back(tp + LONG_T * TP);
    step(tp + (LONG_T + 20) * TP - cyc + 2);
    check("t6_long_done", long_q.size(), 0);
    n0 = cyc;
    bus.btn_in[0] = 1'b0;
    push_evt(third_tick(n0), 4'h0, 4'h1, 4'h0);
    drain("t6_rel_drain", 80);
`endif

    step(2);
    check("final_queue", sb_q.size(), 0);
    check("final_long_queue", long_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
